// File: rtl/prio_encoder_rr_if.sv
// Request/result bundle for the registered round-robin priority encoder.
// master drives requests and out_ready; slave returns the held result.
interface prio_encoder_rr_if #(
   parameter int N = 8
);
   localparam int W = $clog2(N);

   logic         enable;
   logic         mode;
   logic [N-1:0] d_in;
   logic         out_ready;
   logic [W-1:0] y_out;
   logic [N-1:0] onehot_out;
   logic         valid_out;
   logic         multi_out;

   modport master (
      output enable, mode, d_in, out_ready,
      input  y_out, onehot_out, valid_out, multi_out
   );

   modport slave (
      input  enable, mode, d_in, out_ready,
      output y_out, onehot_out, valid_out, multi_out
   );
endinterface

// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) priority encoder with fixed or round-robin priority
// and a valid/ready hold register; no combinational input-to-output path.
//
// state | meaning
// IDLE  | no result held, valid_out=0, waiting for enable with a non-zero d_in
// HOLD  | result held stable until out_ready; may recapture on the same cycle
module prio_encoder_rr #(
   parameter int N = 8
) (
   input logic clk,
   input logic rst_n,
   prio_encoder_rr_if.slave bus
);
   localparam int W = $clog2(N);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t       state_q;
   state_t       state_d;

   logic [W-1:0] ptr_q;
   logic [W-1:0] ptr_d;
   logic         mode_q;
   logic [W-1:0] y_q;
   logic [N-1:0] onehot_q;
   logic         multi_q;

   logic         cap;
   logic         accept;
   logic         load;
   logic [W-1:0] ptr_search;
   logic [W-1:0] win;
   logic [W-1:0] idx;
   logic         found;
   logic [W:0]   pop_cnt;
   logic         multi_d;
   logic [N-1:0] win_onehot;

   assign cap    = bus.enable & (|bus.d_in);
   assign accept = (state_q == HOLD) & bus.out_ready;
   assign load   = cap & ((state_q == IDLE) | accept);

   // The served request drops to lowest priority only if it was granted in RR mode.
   always_comb begin
      ptr_d = ptr_q;
      if (accept && mode_q) begin
         ptr_d = y_q - W'(1);
      end
   end

   // New captures on a handshake cycle already see the rotated pointer.
   assign ptr_search = bus.mode ? ptr_d : W'(N - 1);

   always_comb begin
      win   = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx = ptr_search - W'(k);
         if (!found && bus.d_in[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      pop_cnt = '0;
      for (int i = 0; i < N; i++) begin
         pop_cnt = pop_cnt + {{W{1'b0}}, bus.d_in[i]};
      end
   end

   assign multi_d    = (pop_cnt > (W + 1)'(1));
   assign win_onehot = {{(N - 1){1'b0}}, 1'b1} << win;

   // FSM: state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (cap) begin
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (bus.out_ready && !cap) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM: outputs, all taken from registers
   always_comb begin
      bus.valid_out  = (state_q == HOLD);
      bus.y_out      = y_q;
      bus.onehot_out = onehot_q;
      bus.multi_out  = multi_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q    <= W'(N - 1);
         mode_q   <= 1'b0;
         y_q      <= '0;
         onehot_q <= '0;
         multi_q  <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
         if (load) begin
            y_q      <= win;
            onehot_q <= win_onehot;
            multi_q  <= multi_d;
            mode_q   <= bus.mode;
         end
      end
   end
endmodule

// File: tb/tb_prio_encoder_rr.sv
// Bench for prio_encoder_rr: N=4 and N=8 instances, a directed vector table,
// hand-written corner sequences, and a queue-based scoreboard with random traffic.
module tb_prio_encoder_rr;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   prio_encoder_rr_if #(.N(4)) bus4 ();
   prio_encoder_rr_if #(.N(8)) bus8 ();

   prio_encoder_rr #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
   prio_encoder_rr #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

   typedef struct packed {
      logic [2:0] y;
      logic [7:0] oh;
      logic       multi;
   } exp_t;

   typedef struct {
      bit         en;
      bit         md;
      logic [3:0] d;
      bit         rdy;
      bit         ev;
      int         ey;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   exp_t q4[$];
   exp_t q8[$];
   exp_t cur [2];
   bit   m_valid [2];
   int   m_ptr [2];
   bit   m_mode [2];
   int   m_y [2];
   bit   new_load [2];

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int model_win(logic [7:0] d, int p, int n);
      for (int k = 0; k < n; k++) begin
         int idx;
         idx = (p - k + n) % n;
         if (d[idx]) return idx;
      end
      return 0;
   endfunction

   task automatic model_step(int w, bit en, bit md, logic [7:0] d, bit rdy);
      int         n;
      logic [7:0] dm;
      bit         cap, acc, ld;
      int         win;
      exp_t       e;
      n   = (w != 0) ? 8 : 4;
      dm  = d & 8'((1 << n) - 1);
      cap = en && (dm != 0);
      acc = m_valid[w] && rdy;
      if (acc && m_mode[w]) m_ptr[w] = (m_y[w] - 1 + n) % n;
      ld = cap && (!m_valid[w] || acc);
      if (ld) begin
         win       = model_win(dm, md ? m_ptr[w] : n - 1, n);
         m_y[w]    = win;
         m_mode[w] = md;
         e.y       = 3'(win);
         e.oh      = 8'(1) << win;
         e.multi   = ($countones(dm) > 1);
         if (w != 0) q8.push_back(e);
         else        q4.push_back(e);
         m_valid[w] = 1'b1;
      end else if (acc) begin
         m_valid[w] = 1'b0;
      end
      new_load[w] = ld;
   endtask

   task automatic check_dut(int w);
      int   av, ay, aoh, am;
      string t;
      t = (w != 0) ? "n8" : "n4";
      if (w != 0) begin
         av = int'(bus8.valid_out); ay = int'(bus8.y_out);
         aoh = int'(bus8.onehot_out); am = int'(bus8.multi_out);
      end else begin
         av = int'(bus4.valid_out); ay = int'(bus4.y_out);
         aoh = int'(bus4.onehot_out); am = int'(bus4.multi_out);
      end
      check({t, "_valid"}, av, int'(m_valid[w]));
      if (m_valid[w]) begin
         if (new_load[w]) begin
            if (w != 0 && q8.size() > 0)      cur[w] = q8.pop_front();
            else if (w == 0 && q4.size() > 0) cur[w] = q4.pop_front();
         end
         check({t, "_y"}, ay, int'(cur[w].y));
         check({t, "_onehot"}, aoh, int'(cur[w].oh));
         check({t, "_multi"}, am, int'(cur[w].multi));
      end
   endtask

   task automatic cyc(int w, bit en, bit md, logic [7:0] d, bit rdy);
      if (w != 0) begin
         bus8.enable = en; bus8.mode = md; bus8.d_in = d; bus8.out_ready = rdy;
         bus4.enable = 1'b0; bus4.out_ready = 1'b1;
      end else begin
         bus4.enable = en; bus4.mode = md; bus4.d_in = d[3:0]; bus4.out_ready = rdy;
         bus8.enable = 1'b0; bus8.out_ready = 1'b1;
      end
      model_step(0, bus4.enable, bus4.mode, {4'b0, bus4.d_in}, bus4.out_ready);
      model_step(1, bus8.enable, bus8.mode, bus8.d_in, bus8.out_ready);
      @(posedge clk);
      #1;
      check_dut(0);
      check_dut(1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int w = 0; w < 2; w++) begin
         m_valid[w] = 1'b0; m_mode[w] = 1'b0; m_y[w] = 0; new_load[w] = 1'b0;
         m_ptr[w] = (w != 0) ? 7 : 3;
      end
      q4.delete();
      q8.delete();
      check("rst_valid4", int'(bus4.valid_out), 0);
      check("rst_y4", int'(bus4.y_out), 0);
      check("rst_onehot4", int'(bus4.onehot_out), 0);
      check("rst_multi4", int'(bus4.multi_out), 0);
      check("rst_valid8", int'(bus8.valid_out), 0);
      check("rst_y8", int'(bus8.y_out), 0);
   endtask

   vec_t tbl [14];

   initial begin
      tbl[0]  = '{1, 0, 4'b0001, 1, 1, 0};
      tbl[1]  = '{1, 0, 4'b0010, 1, 1, 1};
      tbl[2]  = '{1, 0, 4'b0100, 1, 1, 2};
      tbl[3]  = '{1, 0, 4'b1000, 1, 1, 3};
      tbl[4]  = '{1, 0, 4'b1011, 1, 1, 3};
      tbl[5]  = '{1, 0, 4'b0000, 1, 0, 0};
      tbl[6]  = '{0, 0, 4'b0001, 1, 0, 0};
      tbl[7]  = '{1, 1, 4'b1111, 1, 1, 3};
      tbl[8]  = '{1, 1, 4'b1111, 1, 1, 2};
      tbl[9]  = '{1, 1, 4'b1111, 1, 1, 1};
      tbl[10] = '{1, 1, 4'b1111, 1, 1, 0};
      tbl[11] = '{1, 1, 4'b1111, 1, 1, 3};
      tbl[12] = '{1, 1, 4'b1111, 1, 1, 2};
      tbl[13] = '{0, 1, 4'b1111, 1, 0, 0};

      rst_n = 1'b1;
      bus4.enable = 1'b0; bus4.mode = 1'b0; bus4.d_in = '0; bus4.out_ready = 1'b1;
      bus8.enable = 1'b0; bus8.mode = 1'b0; bus8.d_in = '0; bus8.out_ready = 1'b1;
      #2;
      do_reset();

      for (int i = 0; i < 14; i++) begin
         cyc(0, tbl[i].en, tbl[i].md, {4'b0, tbl[i].d}, tbl[i].rdy);
         check($sformatf("tbl%0d_valid", i), int'(bus4.valid_out), int'(tbl[i].ev));
         if (tbl[i].ev) check($sformatf("tbl%0d_y", i), int'(bus4.y_out), tbl[i].ey);
         if (i == 4) begin
            check("tbl4_onehot", int'(bus4.onehot_out), 8);
            check("tbl4_multi", int'(bus4.multi_out), 1);
         end
      end

      // Held result ignores d_in and mode until the handshake.
      do_reset();
      cyc(0, 1, 1, 8'b0100, 0);
      check("hold_cap_y", int'(bus4.y_out), 2);
      for (int i = 0; i < 5; i++) begin
         cyc(0, 1, i[0], 8'b0001, 0);
         check("hold_y", int'(bus4.y_out), 2);
         check("hold_valid", int'(bus4.valid_out), 1);
      end
      cyc(0, 1, 1, 8'b0001, 1);
      check("hold_release_y", int'(bus4.y_out), 0);
      check("hold_release_valid", int'(bus4.valid_out), 1);

      // Reset in HOLD after two RR grants restores the pointer.
      do_reset();
      cyc(0, 1, 1, 8'b1111, 0);
      cyc(0, 1, 1, 8'b1111, 0);
      cyc(0, 1, 1, 8'b1111, 1);
      check("rr2_y", int'(bus4.y_out), 2);
      do_reset();
      cyc(0, 1, 1, 8'b1111, 1);
      check("post_rst_y", int'(bus4.y_out), 3);

      // N=8 alternation between the two extreme requests.
      do_reset();
      for (int i = 0; i < 6; i++) begin
         cyc(1, 1, 1, 8'b1000_0001, 1);
         check("n8_alt_y", int'(bus8.y_out), (i % 2 == 0) ? 7 : 0);
      end
      cyc(1, 1, 1, 8'h00, 1);
      for (int i = 0; i < 4; i++) begin
         cyc(1, 1, 1, 8'h00, 1);
         check("n8_zero_valid", int'(bus8.valid_out), 0);
      end

      for (int i = 0; i < 400; i++) begin
         logic [7:0] d;
         d = 8'($urandom);
         if ($urandom_range(0, 7) == 0) d = '0;
         cyc(int'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
             1'($urandom_range(0, 1)), d, $urandom_range(0, 2) != 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/prio_encoder_rr.md
Name: prio_encoder_rr

Overview:
Parametrised, registered N-to-log2(N) priority encoder. It is the next generation of the team's 4-to-2 enable-gated encoder. It adds two modes: fixed priority and round-robin fairness. Each captured result is held in an output register under a valid/ready handshake, so it can feed arbitration and interrupt-request logic in a pipelined datapath.

Parameters:
N, 8, number of request inputs; power of two, N >= 2.
W, $clog2(N), width of the encoded index (derived; not overridden).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
enable  input  1  allows capture of a new request vector
mode  input  1  0 = fixed priority, 1 = round-robin
d_in  input  N  request vector; bit i = request i
out_ready  input  1  downstream accepts the held result
y_out  output  W  encoded index of the winning request
onehot_out  output  N  one-hot of the winner
valid_out  output  1  y_out/onehot_out/multi_out are valid and held
multi_out  output  1  more than one d_in bit was set at capture

Behaviour:
- Reset: one clock, synchronous, active-low.
  - On a clk edge with rst_n=0: y_out=0, onehot_out=0, valid_out=0, multi_out=0, ptr=N-1, state=IDLE.
  - A reset asserted mid-HOLD discards the held result.
- Internal pointer ptr (W bits) names the highest-priority index.
- Search order: ptr, ptr-1, ..., 0, N-1, ..., ptr+1. The first set bit wins.
- Fixed mode (mode=0): search always uses ptr_eff=N-1, so the highest set index wins. ptr is not modified.
- Round-robin mode (mode=1): search uses ptr_eff=ptr.
  - On each accepted result, ptr <= (granted index - 1) mod N, wrapping 0 -> N-1.
  - The just-served request therefore becomes lowest priority.
- mode is sampled only at capture. A mode change while in HOLD has no effect on the held result.
- Capture condition: cap = enable & (d_in != 0).
- FSM states: IDLE, HOLD.
  - IDLE, cap=1: register the winner into y_out/onehot_out, set multi_out = (popcount(d_in) > 1), valid_out=1, go to HOLD. Latency is 1 cycle from d_in to valid_out.
  - IDLE, cap=0: stay in IDLE, valid_out=0. d_in=0 or enable=0 never produces a result. Outputs keep their last values and are don't-care while valid_out=0.
  - HOLD, out_ready=0: all outputs are stable. enable and d_in are ignored; requests are not queued.
  - HOLD, out_ready=1 (handshake): update ptr if mode=1 was sampled.
    - Then, if cap=1 in the same cycle, capture a new result using the updated pointer and stay in HOLD, with valid_out continuously 1 (back-to-back, full throughput).
    - Otherwise go to IDLE with valid_out=0.
- out_ready in IDLE is ignored.
- Combinational paths: the only paths are from d_in/enable/mode to the capture registers. No input-to-output combinational path exists.
- onehot_out always equals 1 << y_out when valid_out=1.

Test Plan:
- N=4, mode=0, enable=1, out_ready=1; d_in 0001, 0010, 0100, 1000 on successive cycles -> y_out 0, 1, 2, 3 one cycle after each input, with valid_out held at 1 throughout and multi_out=0.
- N=4, mode=0, d_in=1011 -> y_out=3, onehot_out=1000, multi_out=1. Then with enable=0 or d_in=0000 -> valid_out drops to 0 the cycle after the accept.
- N=4, mode=1, d_in held at 1111, out_ready=1 from reset -> y_out sequence 3, 2, 1, 0, 3, ... and ptr wraps correctly.
- Hold test: capture d_in=0100; keep out_ready=0 for 5 cycles while d_in toggles to 0001 and mode toggles -> y_out stays 2 and valid_out stays 1. Raise out_ready -> next result reflects the current d_in (0) with the RR pointer updated.
- Reset mid-operation: in HOLD with mode=1 after two grants, pulse rst_n=0 for one cycle -> next edge gives valid_out=0 and y_out=0. The next capture of d_in=1111 gives y_out=3 (ptr back to N-1).
- N=8 parameter sweep: mode=1, d_in=1000_0001 held -> grants alternate 7, 0, 7, 0. With d_in=0 -> valid_out never asserts.
